// File: rtl/floor_texture_gen.sv
// Animated floor texture: maps (x,y) to an RGB565 colour in one of four patterns, with scrolling offset.
// Latency 2 cycles (in_valid -> out_valid); one pixel per cycle, never stalls. Mode/offset change only at frame_tick.
module floor_texture_gen #(
   parameter int          PERIOD     = 6,
   parameter int          LIGHT_ROWS = 4,
   parameter logic [15:0] COLOR_A    = 16'h9A00,
   parameter logic [15:0] COLOR_B    = 16'h5940,
   parameter int          SCROLL_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  x,
   input  logic [6:0]  y,
   input  logic        in_valid,
   input  logic        frame_tick,
   input  logic [1:0]  mode_in,
   input  logic        mode_wr,
   input  logic        scroll_en,
   input  logic        scroll_dir,
   output logic [15:0] oled_data,
   output logic        out_valid,
   output logic        mode_busy
);

   localparam logic [4:0] OFF_MAX = 5'(2 * PERIOD - 1);
   localparam logic [7:0] DIV_MAX = 8'(SCROLL_DIV - 1);
   localparam logic [7:0] P8      = 8'(PERIOD);
   localparam logic [7:0] LR8     = 8'(LIGHT_ROWS);
   localparam logic [7:0] HALF8   = 8'(PERIOD / 2);

   logic [1:0]  mode_act;
   logic [1:0]  mode_pend;
   logic [4:0]  off;
   logic [7:0]  div;

   logic        s1_vld;
   logic [7:0]  s1_sx;
   logic [7:0]  s1_sy;
   logic [6:0]  s1_x;
   logic [1:0]  s1_mode;

   logic [7:0]  ry;
   logic [7:0]  rx;
   logic        by_odd;
   logic        bx_odd;
   logic [7:0]  brick_col;
   logic [15:0] color;

   // A write coincident with the tick bypasses the pending register entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_act  <= 2'd0;
         mode_pend <= 2'd0;
         mode_busy <= 1'b0;
      end else if (frame_tick) begin
         if (mode_wr) begin
            mode_act  <= mode_in;
            mode_pend <= mode_in;
            mode_busy <= 1'b0;
         end else if (mode_busy) begin
            mode_act  <= mode_pend;
            mode_busy <= 1'b0;
         end
      end else if (mode_wr) begin
         mode_pend <= mode_in;
         mode_busy <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div <= 8'd0;
         off <= 5'd0;
      end else if (frame_tick && scroll_en) begin
         if (div == DIV_MAX) begin
            div <= 8'd0;
            if (scroll_dir)
               off <= (off == 5'd0) ? OFF_MAX : off - 5'd1;
            else
               off <= (off == OFF_MAX) ? 5'd0 : off + 5'd1;
         end else begin
            div <= div + 8'd1;
         end
      end
   end

   // Stage 1 snapshots the settings so in-flight pixels keep the ones they entered with.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld  <= 1'b0;
         s1_sx   <= 8'd0;
         s1_sy   <= 8'd0;
         s1_x    <= 7'd0;
         s1_mode <= 2'd0;
      end else begin
         s1_vld  <= in_valid;
         s1_sx   <= {1'b0, x} + {3'b000, off};
         s1_sy   <= {1'b0, y} + {3'b000, off};
         s1_x    <= x;
         s1_mode <= mode_act;
      end
   end

   always_comb begin
      ry        = s1_sy % P8;
      rx        = s1_sx % P8;
      by_odd    = ((s1_sy / P8) & 8'd1) != 8'd0;
      bx_odd    = ((s1_sx / P8) & 8'd1) != 8'd0;
      brick_col = ({1'b0, s1_x} + (by_odd ? HALF8 : 8'd0)) % P8;
      color     = COLOR_B;
      case (s1_mode)
         2'd0: color = (ry < LR8) ? COLOR_A : COLOR_B;
         2'd1: color = (rx < LR8) ? COLOR_A : COLOR_B;
         2'd2: color = (by_odd ^ bx_odd) ? COLOR_B : COLOR_A;
         2'd3: color = ((ry >= LR8) || (brick_col == 8'd0)) ? COLOR_B : COLOR_A;
         default: color = COLOR_B;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         oled_data <= 16'h0000;
      end else begin
         out_valid <= s1_vld;
         if (s1_vld)
            oled_data <= color;
      end
   end

endmodule

// File: tb/tb_floor_texture_gen.sv
// Bench for floor_texture_gen: directed steps plus a randomized stretch, checked against an arithmetic reference model.
module tb_floor_texture_gen;

   localparam int          P  = 6;
   localparam int          L  = 4;
   localparam int          SD = 4;
   localparam logic [15:0] CA = 16'h9A00;
   localparam logic [15:0] CB = 16'h5940;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  x;
   logic [6:0]  y;
   logic        in_valid;
   logic        frame_tick;
   logic [1:0]  mode_in;
   logic        mode_wr;
   logic        scroll_en;
   logic        scroll_dir;
   logic [15:0] oled_data;
   logic        out_valid;
   logic        mode_busy;

   always #5 clk = ~clk;

   floor_texture_gen dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .in_valid(in_valid),
      .frame_tick(frame_tick), .mode_in(mode_in), .mode_wr(mode_wr),
      .scroll_en(scroll_en), .scroll_dir(scroll_dir),
      .oled_data(oled_data), .out_valid(out_valid), .mode_busy(mode_busy)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int m_mode = 0, m_pend = 0, m_off = 0, m_div = 0;
   bit m_busy = 1'b0;

   typedef struct { bit vld; logic [15:0] col; } exp_t;
   exp_t        hist[$];
   logic [15:0] last_col = 16'h0000;

   function automatic logic [15:0] ref_color(int mode, int off, int px, int py);
      int sx = px + off;
      int sy = py + off;
      int ry = sy % P;
      int rx = sx % P;
      int by = sy / P;
      int bx = sx / P;
      case (mode)
         0: return (ry < L) ? CA : CB;
         1: return (rx < L) ? CA : CB;
         2: return ((by % 2) == (bx % 2)) ? CA : CB;
         default: return (ry >= L || ((px + ((by % 2) ? P / 2 : 0)) % P) == 0) ? CB : CA;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: model predicts, DUT steps, outputs compared.
   task automatic cyc(bit v, int px, int py, bit ft, bit mw, int mi, bit se, bit sd);
      exp_t        e;
      logic [15:0] ec;
      in_valid   = v;
      x          = 7'(px);
      y          = 7'(py);
      frame_tick = ft;
      mode_wr    = mw;
      mode_in    = 2'(mi);
      scroll_en  = se;
      scroll_dir = sd;
      hist.push_back('{v, ref_color(m_mode, m_off, px, py)});
      if (ft) begin
         if (mw) begin
            m_mode = mi; m_pend = mi; m_busy = 1'b0;
         end else if (m_busy) begin
            m_mode = m_pend; m_busy = 1'b0;
         end
         if (se) begin
            m_div = m_div + 1;
            if (m_div == SD) begin
               m_div = 0;
               m_off = sd ? (m_off + 2 * P - 1) % (2 * P) : (m_off + 1) % (2 * P);
            end
         end
      end else if (mw) begin
         m_pend = mi; m_busy = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hist.size() >= 2) e = hist[hist.size() - 2];
      else e = '{1'b0, last_col};
      ec = e.vld ? e.col : last_col;
      chk("out_valid", 32'(out_valid), 32'(e.vld));
      chk("oled_data", 32'(oled_data), 32'(ec));
      chk("mode_busy", 32'(mode_busy), 32'(m_busy));
      if (e.vld) last_col = e.col;
      if (hist.size() > 4) void'(hist.pop_front());
      in_valid = 1'b0; frame_tick = 1'b0; mode_wr = 1'b0;
   endtask

   // Reset with every other control asserted, to exercise reset priority.
   task automatic do_reset(bit v);
      reset = 1'b1; in_valid = v; x = 7'd5; y = 7'd9;
      frame_tick = 1'b1; mode_wr = 1'b1; mode_in = 2'd3; scroll_en = 1'b1; scroll_dir = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0; frame_tick = 1'b0; mode_wr = 1'b0; scroll_en = 1'b0;
      m_mode = 0; m_pend = 0; m_off = 0; m_div = 0; m_busy = 1'b0;
      hist.delete();
      last_col = 16'h0000;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_oled_data", 32'(oled_data), 32'h0);
      chk("rst_mode_busy", 32'(mode_busy), 32'd0);
      chk("rst_off", 32'(dut.off), 32'd0);
   endtask

   task automatic pix(string tag, int px, int py, logic [15:0] exp);
      cyc(1'b1, px, py, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk(tag, 32'(oled_data), 32'(exp));
   endtask

   task automatic ticks(int n, bit sd);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b1, sd);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; frame_tick = 1'b0;
      mode_in = '0; mode_wr = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
      do_reset(1'b0);
      do_reset(1'b1);

      // Horizontal stripes, continuous stream down column 0.
      for (int i = 0; i < 14; i++) begin
         cyc(i < 12, 0, i, 1'b0, 1'b0, 0, 1'b0, 1'b0);
         if (i >= 1 && i <= 12) chk("stripe_y", 32'(oled_data), ((i - 1) % 6 < 4) ? 32'(CA) : 32'(CB));
      end

      // Scrolling forward, wrap, and backward.
      ticks(4, 1'b0);
      chk("off_after_4", 32'(dut.off), 32'd1);
      pix("scroll_y3", 0, 3, CB);
      ticks(40, 1'b0);
      chk("off_after_44", 32'(dut.off), 32'd11);
      ticks(4, 1'b0);
      chk("off_wrap_up", 32'(dut.off), 32'd0);
      ticks(4, 1'b1);
      chk("off_wrap_down", 32'(dut.off), 32'd11);
      ticks(4, 1'b0);
      chk("off_restored", 32'(dut.off), 32'd0);

      // Pending mode write applies only at the tick.
      cyc(1'b0, 0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      chk("busy_after_wr", 32'(mode_busy), 32'd1);
      pix("still_stripes", 6, 0, CA);
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("busy_cleared", 32'(mode_busy), 32'd0);
      pix("checker_00", 0, 0, CA);
      pix("checker_60", 6, 0, CB);

      // Last write wins: brick.
      cyc(1'b0, 0, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      pix("brick_00", 0, 0, CB);
      pix("brick_10", 1, 0, CA);
      pix("brick_36", 3, 6, CB);

      // Write coincident with tick overrides older pending; pixel on the tick cycle keeps old mode.
      cyc(1'b0, 0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      cyc(1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
      chk("coinc_busy", 32'(mode_busy), 32'd0);
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("inflight_old_mode", 32'(oled_data), 32'(CB));
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("next_new_mode", 32'(oled_data), 32'(CA));

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 4) != 0, int'($urandom_range(0, 95)), int'($urandom_range(0, 63)),
             ($urandom % 5) == 0, ($urandom % 7) == 0, int'($urandom % 4),
             ($urandom % 4) != 0, ($urandom % 2) == 1);
      end
      chk("rand_off", 32'(dut.off), 32'(m_off));

      // Reset mid-stream drops in-flight pixels and returns to defaults.
      for (int i = 0; i < 3; i++) cyc(1'b1, i, i, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      do_reset(1'b1);
      cyc(1'b1, 0, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("post_rst_gap", 32'(out_valid), 32'd0);
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_mode0", 32'(oled_data), 32'(CB));
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("post_rst_pix2", 32'(oled_data), 32'(CA));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
